// File: rtl/branch_resolver.sv
// branch_resolver: in-order FIFO of fetch predictions, paired with
// execute outcomes to produce the registered predictor update bundle.
//
// Ports:
//   clk_i, rst_n_i       clock, synchronous active-low reset
//   flush_i              drop all buffered predictions
//   push_valid_i/_ready_o, pred_*_i   prediction push from fetch
//   exe_valid_i, exe_*_i              resolved branch from execute
//   res_*_o              registered update / redirect bundle
//   err_o                registered pulse: resolve with no matching head
//   count_o              current occupancy

package mmm_pkg;
  parameter int XLEN = 32;
  parameter int HLEN = 10;
endpackage

module branch_resolver
  import mmm_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            push_valid_i,
  output logic            push_ready_o,
  input  logic [XLEN-1:0] pred_pc_i,
  input  logic [HLEN-1:0] pred_index_i,
  input  logic [XLEN-1:0] pred_target_i,
  input  logic            pred_taken_i,
  input  logic            exe_valid_i,
  input  logic [XLEN-1:0] exe_pc_i,
  input  logic [XLEN-1:0] exe_target_i,
  input  logic            exe_taken_i,
  output logic            res_valid_o,
  output logic [XLEN-1:0] res_pc_o,
  output logic [HLEN-1:0] res_index_o,
  output logic [XLEN-1:0] res_target_o,
  output logic            res_taken_o,
  output logic            res_mispredict_o,
  output logic            err_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [HLEN-1:0] index;
    logic [XLEN-1:0] target;
    logic            taken;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            res_valid_q, res_valid_d;
  logic [XLEN-1:0] res_pc_q, res_pc_d;
  logic [HLEN-1:0] res_index_q, res_index_d;
  logic [XLEN-1:0] res_target_q, res_target_d;
  logic            res_taken_q, res_taken_d;
  logic            res_misp_q, res_misp_d;
  logic            err_q, err_d;

  entry_t head;
  logic   push_ready;
  logic   push_acc;
  logic   hit;
  logic   pop;
  logic   misp;

  assign head       = mem_q[rd_ptr_q];
  // Ready looks only at registered occupancy; a same-cycle pop
  // does not lend a slot.
  assign push_ready = (count_q < CW'(DEPTH));
  assign push_acc   = push_valid_i & push_ready & ~flush_i;
  // An entry pushed this cycle is not visible until count_q sees it.
  assign hit        = exe_valid_i & (count_q != '0)
                    & (head.pc == exe_pc_i);
  assign pop        = hit & ~flush_i;

  // Wrong direction, or taken both ways but to a different place.
  assign misp = (head.taken != exe_taken_i)
              | (head.taken & exe_taken_i
                 & (head.target != exe_target_i));

  always_comb begin
    mem_d = mem_q;
    if (push_acc) begin
      mem_d[wr_ptr_q] = '{
        pc:     pred_pc_i,
        index:  pred_index_i,
        target: pred_target_i,
        taken:  pred_taken_i
      };
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_acc) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push_acc) - CW'(pop);
    end
  end

  always_comb begin
    res_valid_d  = 1'b0;
    res_misp_d   = 1'b0;
    err_d        = 1'b0;
    res_pc_d     = res_pc_q;
    res_index_d  = res_index_q;
    res_target_d = res_target_q;
    res_taken_d  = res_taken_q;
    if (!flush_i && exe_valid_i) begin
      if (hit) begin
        res_valid_d  = 1'b1;
        res_pc_d     = head.pc;
        res_index_d  = head.index;
        res_target_d = exe_target_i;
        res_taken_d  = exe_taken_i;
        res_misp_d   = misp;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Entry storage is never cleared; pointers alone define contents.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      res_valid_q  <= 1'b0;
      res_pc_q     <= '0;
      res_index_q  <= '0;
      res_target_q <= '0;
      res_taken_q  <= 1'b0;
      res_misp_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      res_valid_q  <= res_valid_d;
      res_pc_q     <= res_pc_d;
      res_index_q  <= res_index_d;
      res_target_q <= res_target_d;
      res_taken_q  <= res_taken_d;
      res_misp_q   <= res_misp_d;
      err_q        <= err_d;
    end
  end

  assign push_ready_o     = push_ready;
  assign count_o          = count_q;
  assign res_valid_o      = res_valid_q;
  assign res_pc_o         = res_pc_q;
  assign res_index_o      = res_index_q;
  assign res_target_o     = res_target_q;
  assign res_taken_o      = res_taken_q;
  assign res_mispredict_o = res_misp_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed stimulus for branch_resolver with a
// queue-based reference model checked on every cycle.

module tb_branch_resolver;
  import mmm_pkg::*;

  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            push_valid;
  logic            push_ready;
  logic [XLEN-1:0] pred_pc;
  logic [HLEN-1:0] pred_index;
  logic [XLEN-1:0] pred_target;
  logic            pred_taken;
  logic            exe_valid;
  logic [XLEN-1:0] exe_pc;
  logic [XLEN-1:0] exe_target;
  logic            exe_taken;
  logic            res_valid;
  logic [XLEN-1:0] res_pc;
  logic [HLEN-1:0] res_index;
  logic [XLEN-1:0] res_target;
  logic            res_taken;
  logic            res_misp;
  logic            err;
  logic [3:0]      count;

  branch_resolver #(.DEPTH(DEPTH)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .flush_i          (flush),
    .push_valid_i     (push_valid),
    .push_ready_o     (push_ready),
    .pred_pc_i        (pred_pc),
    .pred_index_i     (pred_index),
    .pred_target_i    (pred_target),
    .pred_taken_i     (pred_taken),
    .exe_valid_i      (exe_valid),
    .exe_pc_i         (exe_pc),
    .exe_target_i     (exe_target),
    .exe_taken_i      (exe_taken),
    .res_valid_o      (res_valid),
    .res_pc_o         (res_pc),
    .res_index_o      (res_index),
    .res_target_o     (res_target),
    .res_taken_o      (res_taken),
    .res_mispredict_o (res_misp),
    .err_o            (err),
    .count_o          (count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  function automatic void chk(string name, logic [63:0] act,
                              logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference model: a queue of outstanding predictions.
  typedef struct {
    logic [XLEN-1:0] pc;
    logic [HLEN-1:0] idx;
    logic [XLEN-1:0] tgt;
    bit              tk;
  } ent_t;

  ent_t            mq[$];
  bit              m_valid, m_err, m_misp, m_tk;
  logic [XLEN-1:0] m_pc, m_tgt;
  logic [HLEN-1:0] m_idx;

  always @(posedge clk) begin
    automatic bit room = (mq.size() < DEPTH);
    if (!rst_n) begin
      mq.delete();
      m_valid = 0; m_err = 0; m_misp = 0; m_tk = 0;
      m_pc = '0; m_tgt = '0; m_idx = '0;
    end else if (flush) begin
      mq.delete();
      m_valid = 0; m_err = 0; m_misp = 0;
    end else begin
      m_valid = 0; m_err = 0; m_misp = 0;
      if (exe_valid) begin
        if (mq.size() > 0 && mq[0].pc == exe_pc) begin
          m_valid = 1;
          m_pc    = mq[0].pc;
          m_idx   = mq[0].idx;
          m_tgt   = exe_target;
          m_tk    = exe_taken;
          if (mq[0].tk != exe_taken)
            m_misp = 1;
          else if (exe_taken && mq[0].tgt != exe_target)
            m_misp = 1;
          void'(mq.pop_front());
        end else begin
          m_err = 1;
        end
      end
      if (push_valid && room)
        mq.push_back('{pred_pc, pred_index, pred_target,
                       pred_taken});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", count, mq.size());
      chk("ready", push_ready, mq.size() < DEPTH);
      chk("valid", res_valid, m_valid);
      chk("err", err, m_err);
      chk("misp", res_misp, m_misp);
      if (m_valid) begin
        chk("res_pc", res_pc, m_pc);
        chk("res_index", res_index, m_idx);
        chk("res_target", res_target, m_tgt);
        chk("res_taken", res_taken, m_tk);
      end
    end
  end

  task automatic cyc(bit pv, logic [XLEN-1:0] pc,
                     logic [HLEN-1:0] ix, logic [XLEN-1:0] tg,
                     bit tk, bit ev, logic [XLEN-1:0] epc,
                     logic [XLEN-1:0] etg, bit etk, bit fl);
    push_valid  = pv;
    pred_pc     = pc;
    pred_index  = ix;
    pred_target = tg;
    pred_taken  = tk;
    exe_valid   = ev;
    exe_pc      = epc;
    exe_target  = etg;
    exe_taken   = etk;
    flush       = fl;
    @(negedge clk);
  endtask

  task automatic push(logic [XLEN-1:0] pc, logic [HLEN-1:0] ix,
                      logic [XLEN-1:0] tg, bit tk);
    cyc(1, pc, ix, tg, tk, 0, '0, '0, 0, 0);
  endtask

  task automatic resolve(logic [XLEN-1:0] pc,
                         logic [XLEN-1:0] tg, bit tk);
    cyc(0, '0, '0, '0, 0, 1, pc, tg, tk, 0);
  endtask

  task automatic idle();
    cyc(0, '0, '0, '0, 0, 0, '0, '0, 0, 0);
  endtask

  task automatic drain();
    while (mq.size() > 0)
      resolve(mq[0].pc, mq[0].tgt, mq[0].tk);
  endtask

  initial begin
    rst_n = 0;
    push_valid = 0; pred_pc = '0; pred_index = '0;
    pred_target = '0; pred_taken = 0;
    exe_valid = 0; exe_pc = '0; exe_target = '0;
    exe_taken = 0; flush = 0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_count", count, 4'd0);
    chk("rst_ready", push_ready, 1'b1);
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_res_pc", res_pc, 32'h0);
    rst_n = 1;
    idle();

    // Fill, then one rejected extra push
    for (int i = 0; i < 9; i++)
      push(32'h100 + 4 * i, 10'(i), 32'h1000 + i, i[0]);
    chk("fill_count", count, 4'd8);
    chk("fill_ready", push_ready, 1'b0);

    // Full: push rejected, pop taken
    cyc(1, 32'h120, 10'h3F, 32'h0, 0, 1, 32'h100, 32'h1000, 0, 0);
    chk("full_pp_count", count, 4'd7);
    chk("full_pp_valid", res_valid, 1'b1);
    chk("full_pp_pc", res_pc, 32'h100);
    cyc(1, 32'h124, 10'h3E, 32'h0, 0, 1, 32'h104, 32'h1001, 1, 0);
    chk("pp_count", count, 4'd7);

    // Three full wraps with a push and pop every cycle
    for (int i = 0; i < 3 * DEPTH; i++)
      cyc(1, 32'h900 + 4 * i, 10'(i), 32'h2000 + i, i[0],
          1, mq[0].pc, mq[0].tgt, mq[0].tk, 0);
    chk("wrap_count", count, 4'd7);
    drain();
    idle();

    // Resolve with empty FIFO
    resolve(32'h200, 32'h300, 1);
    chk("empty_err", err, 1'b1);
    chk("empty_valid", res_valid, 1'b0);
    idle();
    chk("err_pulse", err, 1'b0);

    // Correct prediction
    push(32'h200, 10'h2A, 32'h300, 1);
    resolve(32'h200, 32'h300, 1);
    chk("ok_valid", res_valid, 1'b1);
    chk("ok_index", res_index, 10'h2A);
    chk("ok_misp", res_misp, 1'b0);
    chk("ok_count", count, 4'd0);

    // Direction mispredict
    push(32'h210, 10'h05, 32'h400, 0);
    resolve(32'h210, 32'h400, 1);
    chk("dir_misp", res_misp, 1'b1);
    chk("dir_target", res_target, 32'h400);

    // Target mispredict
    push(32'h220, 10'h06, 32'h300, 1);
    resolve(32'h220, 32'h304, 1);
    chk("tgt_misp", res_misp, 1'b1);

    // Both not taken, targets differ: not a mispredict
    push(32'h230, 10'h07, 32'h500, 0);
    resolve(32'h230, 32'h600, 0);
    chk("nt_misp", res_misp, 1'b0);

    // PC mismatch keeps the head
    push(32'h200, 10'h11, 32'h300, 1);
    resolve(32'h500, 32'h300, 1);
    chk("mm_err", err, 1'b1);
    chk("mm_count", count, 4'd1);
    resolve(32'h200, 32'h300, 1);
    chk("mm_retry_pc", res_pc, 32'h200);

    // No same-cycle bypass into an empty FIFO
    cyc(1, 32'h800, 10'h12, 32'h880, 1, 1, 32'h800, 32'h880, 1, 0);
    chk("byp_err", err, 1'b1);
    chk("byp_count", count, 4'd1);
    resolve(32'h800, 32'h880, 1);
    chk("byp_valid", res_valid, 1'b1);

    // Flush beats push and resolve
    for (int i = 0; i < 5; i++)
      push(32'h700 + 4 * i, 10'(i), 32'h7000 + i, 1);
    cyc(1, 32'h720, 10'h1, 32'h0, 0, 1, 32'h700, 32'h7000, 1, 1);
    chk("fl_count", count, 4'd0);
    chk("fl_valid", res_valid, 1'b0);
    chk("fl_err", err, 1'b0);
    push(32'h600, 10'h33, 32'h640, 1);
    resolve(32'h600, 32'h640, 1);
    chk("post_fl_pc", res_pc, 32'h600);
    chk("post_fl_idx", res_index, 10'h33);

    // Reset mid-operation
    push(32'h900, 10'h1, 32'h0, 0);
    push(32'h904, 10'h2, 32'h0, 0);
    rst_n = 0;
    idle();
    rst_n = 1;
    chk("midrst_count", count, 4'd0);
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Prediction tracking and resolution stage for the branch prediction unit. It buffers every prediction issued in the fetch stage in an in-order FIFO. When execute resolves a branch, the block pairs the outcome with the oldest buffered prediction, detects a mispredict, and drives the registered `res_*` update bundle back into the branch prediction unit's `res_valid_i`, `res_pc_i`, `res_index_i`, `res_target_i`, `res_taken_i` and `res_mispredict_i` inputs. `res_mispredict_o` also serves as the front-end redirect request.

## Interface
- `DEPTH`, 8: number of in-flight predictions; power of two, ≥ 2.
- `XLEN`, `HLEN`: taken from `mmm_pkg`; not overridable here.

Ports (clock and reset first):
- `clk_i` in 1: single clock; all state updates on the rising edge.
- `rst_n_i` in 1: reset, synchronous and active-low.
- `flush_i` in 1: pipeline flush; discards all buffered predictions.
- `push_valid_i` in 1: fetch presents a prediction for a branch instruction.
- `push_ready_o` out 1: FIFO can accept a push.
- `pred_pc_i` in XLEN: PC of the predicted instruction.
- `pred_index_i` in HLEN: gshare PHT index used for the prediction.
- `pred_target_i` in XLEN: predicted target.
- `pred_taken_i` in 1: predicted direction.
- `exe_valid_i` in 1: execute reports a resolved branch (in program order).
- `exe_pc_i` in XLEN: PC of the resolved branch.
- `exe_target_i` in XLEN: actual target.
- `exe_taken_i` in 1: actual direction.
- `res_valid_o`, `res_pc_o` (XLEN), `res_index_o` (HLEN), `res_target_o` (XLEN), `res_taken_o`, `res_mispredict_o` out: registered resolution bundle.
- `err_o` out 1: one-cycle pulse on a resolution with no matching head entry.
- `count_o` out $clog2(DEPTH)+1: current occupancy.

## Operation
- **Storage:** circular FIFO of {pc, index, target, taken}. Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits.
- **Push:** accepted when `push_valid_i & push_ready_o`. `push_ready_o = (count < DEPTH)`, with no credit taken for a same-cycle pop.
- **Resolve:** evaluated when `exe_valid_i` is high.
  - *Match:* count > 0 and head.pc == `exe_pc_i`.
    - Pop the head.
    - Register `res_valid_o`=1, `res_pc_o`=head.pc, `res_index_o`=head.index, `res_target_o`=`exe_target_i`, `res_taken_o`=`exe_taken_i`.
    - `res_mispredict_o` = (head.taken != `exe_taken_i`) | (head.taken & `exe_taken_i` & (head.target != `exe_target_i`)).
  - *Empty or pc mismatch:* no pop, `res_valid_o`=0, `err_o`=1 for one cycle.
- **Simultaneous push and pop:** both are performed and count is unchanged. This is legal when full: the pop frees a slot, but `push_ready_o` was already 0, so no push occurs.
- **Push into an empty FIFO:** the entry becomes visible to resolve in the next cycle only. There is no same-cycle bypass, so a same-cycle `exe_valid_i` is treated as the empty case.
- **Flush:** `flush_i` has priority over push and resolve in the same cycle.
  - Pointers and count go to 0.
  - Next cycle: `res_valid_o`, `res_mispredict_o` and `err_o` are 0.
  - Entry storage is not cleared.
- **Bundle gating:** `res_*` fields other than valid are don't-care when `res_valid_o`=0. `res_mispredict_o` is forced to 0 when `res_valid_o`=0.

## Timing
- **Reset** (`rst_n_i`=0 at a clock edge):
  - Pointers = 0, count = 0.
  - `res_valid_o` = 0, `res_mispredict_o` = 0, `err_o` = 0.
  - `res_pc_o`, `res_index_o`, `res_target_o`, `res_taken_o` = 0.
  - `push_ready_o` = 1 in the cycle after reset.
  - Reset mid-operation discards all entries and any pending result.
- **Latency:** a resolve at edge N produces `res_*` valid during cycle N+1, lasting exactly one cycle per resolve. Back-to-back resolves give back-to-back results.
- **Combinational paths:**
  - `push_ready_o` and `count_o` depend only on registered state, with no combinational path from inputs.
  - `err_o` is registered, with the same one-cycle latency as `res_*`.
- **Ordering:** the front end must assert `flush_i` no earlier than the cycle in which `res_mispredict_o`=1 is visible. Any resolve in that cycle is dropped, since flush has priority.

## Test plan
- **Reset then fill:** reset, then push 8 entries at pc 0x100..0x11C step 4. Required: `count_o`=8, `push_ready_o`=0. A 9th `push_valid_i` is not accepted and count stays 8.
- **Correct prediction:** push {pc 0x200, index 0x2A, target 0x300, taken 1}, then resolve {pc 0x200, target 0x300, taken 1}. Required next cycle: `res_valid_o`=1, `res_index_o`=0x2A, `res_mispredict_o`=0, `count_o`=0.
- **Mispredict cases:**
  - Direction: pred taken 0, actual taken 1, target 0x400. Required: `res_mispredict_o`=1, `res_target_o`=0x400.
  - Target: pred 0x300 taken, actual 0x304 taken. Required: `res_mispredict_o`=1.
- **Full with simultaneous push and pop:** fill to 8, then assert push and matching resolve in the same cycle. Required: pop occurs, push rejected, count becomes 7. Next cycle a push with resolve keeps count at 7, and pointers wrap correctly (verify FIFO order over 3 full wraps).
- **Error and empty cases:**
  - Resolve with FIFO empty. Required: `err_o`=1 one cycle, `res_valid_o`=0.
  - Resolve pc 0x500 against head 0x200. Required: `err_o`=1 and the head is retained.
- **Flush:** with 5 entries, assert `flush_i` together with a matching resolve and a push. Required: count becomes 0, `res_valid_o`=0 next cycle. Then push/resolve 0x600 works normally.
